// File: rtl/calc_key_controller.sv
// calc_key_controller: keypad sync/debounce, digit accumulation and
// operand/operator sequencing for the calculator register file.
module calc_key_controller #(
  parameter int N               = 32,
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         key_valid,
  input  logic [3:0]   rawKey,
  input  logic [N-1:0] r0,
  input  logic [N-1:0] r1,
  input  logic [N-1:0] alu_result,
  output logic [N-1:0] r_in,
  output logic [3:0]   we,
  output logic         bp,
  output logic         dis_mux_sig,
  output logic [2:0]   mem_reset,
  output logic         busy
);

  typedef enum logic [1:0] {
    PH_IDLE, PH_PRESS, PH_EXEC, PH_DISP
  } phase_t;

  typedef enum logic [1:0] {
    ENTRY_A, ENTRY_B, RESULT
  } seq_t;

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CMAX = CW'(DEBOUNCE_CYCLES - 1);

  logic          r_kv_s1, r_kv_s2;
  logic [3:0]    r_key_s1, r_key_s2;
  logic          r_db;
  logic [CW-1:0] r_cnt;
  logic [3:0]    r_key_q;
  phase_t        r_ph;
  seq_t          r_seq;
  logic          r_chain;

  phase_t        w_ph_n;
  seq_t          w_seq_n;
  logic          w_chain_n;
  logic [N-1:0]  w_rin_n;
  logic [3:0]    w_we_n;
  logic          w_bp_n;
  logic [2:0]    w_mr_n;
  logic          w_dis_n;
  logic          w_busy_n;

  logic          w_mis, w_flip, w_acc;
  logic          w_dig, w_op, w_eq, w_clr;
  logic [N-1:0]  w_dval, w_mac0, w_mac1;

  assign w_mis  = (r_kv_s2 != r_db);
  assign w_flip = w_mis && (r_cnt == CMAX);
  // Only a rising flip while idle becomes a press; busy presses vanish.
  assign w_acc  = w_flip && !r_db && (r_ph == PH_IDLE);

  assign w_dig  = (r_key_q <= 4'h9);
  assign w_op   = (r_key_q >= 4'hA) && (r_key_q <= 4'hD);
  assign w_eq   = (r_key_q == 4'hE);
  assign w_clr  = (r_key_q == 4'hF);

  assign w_dval = N'(r_key_q);
  assign w_mac0 = (r0 << 3) + (r0 << 1) + w_dval;
  assign w_mac1 = (r1 << 3) + (r1 << 1) + w_dval;

  always_comb begin
    w_ph_n    = r_ph;
    w_seq_n   = r_seq;
    w_chain_n = r_chain;
    w_rin_n   = '0;
    w_we_n    = '0;
    w_bp_n    = 1'b0;
    w_mr_n    = '0;
    w_dis_n   = dis_mux_sig;
    w_busy_n  = busy;
    unique case (r_ph)
      PH_IDLE: begin
        w_busy_n = 1'b0;
        if (w_acc) begin
          w_ph_n   = PH_PRESS;
          w_bp_n   = 1'b1;
          w_busy_n = 1'b1;
        end
      end
      PH_PRESS: begin
        w_ph_n    = PH_EXEC;
        w_busy_n  = 1'b1;
        w_chain_n = 1'b0;
        unique case (1'b1)
          w_dig: begin
            case (r_seq)
              ENTRY_A: begin
                w_rin_n = w_mac0;
                w_we_n  = 4'b0001;
              end
              ENTRY_B: begin
                w_rin_n = w_mac1;
                w_we_n  = 4'b0010;
              end
              default: begin
                w_rin_n = w_dval;
                w_we_n  = 4'b0001;
                w_seq_n = ENTRY_A;
              end
            endcase
          end
          w_op: begin
            if (r_seq == ENTRY_B) begin
              // r0 and last_op share an edge: ALU still sees old op
              w_rin_n   = alu_result;
              w_we_n    = 4'b1001;
              w_chain_n = 1'b1;
            end else begin
              w_we_n  = 4'b1000;
              w_mr_n  = 3'b010;
              w_seq_n = ENTRY_B;
            end
          end
          w_eq: begin
            if (r_seq == ENTRY_B) begin
              w_rin_n = alu_result;
              w_we_n  = 4'b0001;
              w_seq_n = RESULT;
            end
          end
          w_clr: begin
            w_mr_n  = 3'b111;
            w_seq_n = ENTRY_A;
          end
          default: ;
        endcase
      end
      PH_EXEC: begin
        w_ph_n   = PH_DISP;
        w_busy_n = 1'b1;
        w_we_n   = 4'b0100;
        w_mr_n   = {1'b0, r_chain, 1'b0};
        w_dis_n  = w_dig && (r_seq == ENTRY_B);
      end
      PH_DISP: begin
        w_ph_n   = PH_IDLE;
        w_busy_n = 1'b0;
      end
      default: w_ph_n = PH_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_kv_s1     <= 1'b0;
      r_kv_s2     <= 1'b0;
      r_key_s1    <= '0;
      r_key_s2    <= '0;
      r_db        <= 1'b0;
      r_cnt       <= '0;
      r_key_q     <= '0;
      r_ph        <= PH_IDLE;
      r_seq       <= ENTRY_A;
      r_chain     <= 1'b0;
      r_in        <= '0;
      we          <= '0;
      bp          <= 1'b0;
      mem_reset   <= 3'b111;
      dis_mux_sig <= 1'b0;
      busy        <= 1'b0;
    end else begin
      r_kv_s1  <= key_valid;
      r_kv_s2  <= r_kv_s1;
      r_key_s1 <= rawKey;
      r_key_s2 <= r_key_s1;
      if (w_mis) begin
        if (w_flip) begin
          r_db  <= ~r_db;
          r_cnt <= '0;
        end else begin
          r_cnt <= r_cnt + 1'b1;
        end
      end else begin
        r_cnt <= '0;
      end
      if (w_acc) r_key_q <= r_key_s2;
      r_ph        <= w_ph_n;
      r_seq       <= w_seq_n;
      r_chain     <= w_chain_n;
      r_in        <= w_rin_n;
      we          <= w_we_n;
      bp          <= w_bp_n;
      mem_reset   <= w_mr_n;
      dis_mux_sig <= w_dis_n;
      busy        <= w_busy_n;
    end
  end

endmodule

// File: tb/tb_calc_key_controller.sv
// Bench for calc_key_controller: register-file/ALU stand-in plus a
// key-level calculator model scheduling the expected output cycles.
module tb_calc_key_controller;

  localparam int N = 8;
  localparam int D = 4;

  logic         clk = 1'b0;
  logic         reset;
  logic         key_valid;
  logic [3:0]   rawKey;
  logic [N-1:0] r0, r1, alu_result;
  logic [N-1:0] r_in;
  logic [3:0]   we;
  logic         bp;
  logic         dis_mux_sig;
  logic [2:0]   mem_reset;
  logic         busy;

  calc_key_controller #(.N(N), .DEBOUNCE_CYCLES(D)) dut (
    .clk(clk), .reset(reset), .key_valid(key_valid), .rawKey(rawKey),
    .r0(r0), .r1(r1), .alu_result(alu_result), .r_in(r_in), .we(we),
    .bp(bp), .dis_mux_sig(dis_mux_sig), .mem_reset(mem_reset),
    .busy(busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [N-1:0] alu(input logic [N-1:0] a,
                                       input logic [N-1:0] b,
                                       input logic [3:0] op);
    case (op)
      4'hA:    return N'(a + b);
      4'hB:    return N'(a - b);
      4'hC:    return N'(a * b);
      4'hD:    return (b == 0) ? '0 : N'(a / b);
      default: return '0;
    endcase
  endfunction

  // register file stand-in
  logic [3:0] ri, last_op;
  always @(posedge clk) begin
    if (mem_reset[0]) r0 <= '0;
    else if (we[0]) r0 <= r_in;
    if (mem_reset[1]) r1 <= '0;
    else if (we[1]) r1 <= r_in;
    if (mem_reset[2]) begin
      ri      <= '0;
      last_op <= '0;
    end else begin
      if (bp) ri <= rawKey;
      if (we[3]) last_op <= ri;
    end
  end
  assign alu_result = alu(r0, r1, last_op);

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // calculator model: A=r0, B=r1, op, st 0=ENTRY_A 1=ENTRY_B 2=RESULT
  logic [N-1:0] mA = '0, mB = '0;
  logic [3:0]   mop = '0;
  int           mst = 0;
  int           pc = -1000;
  logic [N-1:0] x_rin = '0;
  logic [3:0]   x_we = '0;
  logic [2:0]   x_mem = '0, x_dmem = '0;
  logic         x_dis = 1'b0;
  bit           lit_en = 1'b0;
  logic [N-1:0] lit_rin = '0;
  logic [3:0]   lit_we = '0;
  bit           chk_en = 1'b0;

  task automatic model_key(input logic [3:0] k);
    x_rin = '0; x_we = '0; x_mem = '0; x_dmem = '0; x_dis = 1'b0;
    if (k <= 4'h9) begin
      if (mst == 0) begin
        mA = N'(mA * 10 + k); x_rin = mA; x_we = 4'b0001;
      end else if (mst == 1) begin
        mB = N'(mB * 10 + k); x_rin = mB; x_we = 4'b0010; x_dis = 1'b1;
      end else begin
        mA = N'(k); x_rin = mA; x_we = 4'b0001; mst = 0;
      end
    end else if (k <= 4'hD) begin
      if (mst == 1) begin
        mA = alu(mA, mB, mop); x_rin = mA; x_we = 4'b1001;
        x_dmem = 3'b010;
      end else begin
        x_we = 4'b1000; x_mem = 3'b010; mst = 1;
      end
      mop = k; mB = '0;
    end else if (k == 4'hE) begin
      if (mst == 1) begin
        mA = alu(mA, mB, mop); x_rin = mA; x_we = 4'b0001; mst = 2;
      end
    end else begin
      mA = '0; mB = '0; mop = '0; mst = 0; x_mem = 3'b111;
    end
  endtask

  logic         e_bp, e_busy;
  logic [3:0]   e_we;
  logic [2:0]   e_mem;
  logic [N-1:0] e_rin;

  always @(negedge clk) begin
    if (chk_en) begin
      e_bp = 1'b0; e_busy = 1'b0; e_we = '0; e_mem = '0; e_rin = '0;
      if (cyc == pc) begin
        e_bp = 1'b1; e_busy = 1'b1;
      end else if (cyc == pc + 1) begin
        e_busy = 1'b1; e_we = x_we; e_mem = x_mem; e_rin = x_rin;
        if (lit_en) begin
          chk("lit_rin", r_in, lit_rin);
          chk("lit_we", we, lit_we);
        end
      end else if (cyc == pc + 2) begin
        e_busy = 1'b1; e_we = 4'b0100; e_mem = x_dmem;
        chk("dis_mux", dis_mux_sig, x_dis);
      end
      chk("bp", bp, e_bp);
      chk("busy", busy, e_busy);
      chk("we", we, e_we);
      chk("mem_reset", mem_reset, e_mem);
      chk("r_in", r_in, e_rin);
    end
  end

  task automatic press(input logic [3:0] k, input bit le,
                       input logic [N-1:0] lr, input logic [3:0] lw,
                       input bit glitch);
    int h, l, g;
    if (glitch) begin
      g = $urandom_range(1, D - 1);
      @(posedge clk); #1;
      key_valid = 1'b1; rawKey = 4'($urandom);
      repeat (g) @(posedge clk);
      #1 key_valid = 1'b0;
      repeat (3) @(posedge clk);
    end
    @(posedge clk); #1;
    model_key(k);
    lit_en = le; lit_rin = lr; lit_we = lw;
    pc = cyc + 2 + D;
    key_valid = 1'b1; rawKey = k;
    h = $urandom_range(D + 3, D + 8);
    repeat (h) @(posedge clk);
    #1 key_valid = 1'b0;
    l = $urandom_range(D + 4, D + 9);
    repeat (l) @(posedge clk);
  endtask

  initial begin
    reset = 1'b0; key_valid = 1'b0; rawKey = '0;
    repeat (3) begin
      @(negedge clk);
      chk("rst_mem", mem_reset, 3'b111);
      chk("rst_we", we, 4'b0000);
      chk("rst_bp", bp, 1'b0);
      chk("rst_busy", busy, 1'b0);
      chk("rst_rin", r_in, 0);
      chk("rst_dis", dis_mux_sig, 1'b0);
    end
    @(negedge clk) reset = 1'b1;
    @(posedge clk); #1;
    chk("rel_mem", mem_reset, 3'b000);
    chk("rel_busy", busy, 1'b0);
    chk_en = 1'b1;

    // bounce: 2-cycle pulses never survive a 4-cycle debounce
    repeat (5) begin
      key_valid = 1'b1; rawKey = 4'h3;
      repeat (2) @(posedge clk);
      #1 key_valid = 1'b0;
      repeat (2) @(posedge clk);
      #1;
    end
    repeat (10) @(posedge clk);

    press(4'h1, 1, 8'd1,   4'b0001, 0);
    press(4'h2, 1, 8'd12,  4'b0001, 0);
    press(4'hA, 1, 8'd0,   4'b1000, 0);
    press(4'h7, 1, 8'd7,   4'b0010, 0);
    press(4'hE, 1, 8'd19,  4'b0001, 0);
    press(4'hB, 1, 8'd0,   4'b1000, 1);
    press(4'h4, 1, 8'd4,   4'b0010, 0);
    press(4'hA, 1, 8'd15,  4'b1001, 0);
    press(4'hE, 1, 8'd15,  4'b0001, 1);
    press(4'h5, 1, 8'd5,   4'b0001, 0);
    press(4'hC, 1, 8'd0,   4'b1000, 0);
    press(4'h6, 1, 8'd6,   4'b0010, 0);
    press(4'hF, 1, 8'd0,   4'b0000, 0);
    press(4'h2, 1, 8'd2,   4'b0001, 0);
    press(4'h0, 1, 8'd20,  4'b0001, 0);
    press(4'h0, 1, 8'd200, 4'b0001, 0);
    press(4'h3, 1, 8'd211, 4'b0001, 1);

    repeat (40) begin
      press(4'($urandom_range(0, 15)), 0, '0, '0,
            ($urandom_range(0, 3) == 0));
    end

    // reset during EXEC
    @(posedge clk); #1;
    model_key(4'h8);
    lit_en = 1'b0;
    pc = cyc + 2 + D;
    key_valid = 1'b1; rawKey = 4'h8;
    repeat (3 + D) @(posedge clk);
    #2;
    chk("abort_pre_we", we, x_we);
    chk_en = 1'b0;
    reset = 1'b0;
    #1;
    chk("abort_we", we, 4'b0000);
    chk("abort_mem", mem_reset, 3'b111);
    chk("abort_busy", busy, 1'b0);
    chk("abort_rin", r_in, 0);
    repeat (2) @(posedge clk);
    #1 key_valid = 1'b0;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
